// File: rtl/stopwatch_timer_ctrl_pkg.sv
// Shared types and helpers for the stopwatch/timer front-panel controller.
//   ctrl_state_t : IDLE / RUNNING / PAUSED / ALARM sequencer states
//   MODE_*       : encoding of the mode select seen by the wrapper
//   cmd_t        : bundle of the one-cycle command pulses
//   cnt_width()  : bit width needed to hold a counter value 0..max_val
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, ALARM} ctrl_state_t;

  localparam logic MODE_STOPWATCH = 1'b1;
  localparam logic MODE_TIMER     = 1'b0;

  typedef struct packed {
    logic start;
    logic stop;
    logic reset;
    logic inc_min;
    logic inc_sec;
  } cmd_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stopwatch_timer_ctrl_if.sv
// Front-panel bundle between the debouncers, the controller and the
// stopwatch/timer wrapper.
//   master : panel side, drives switch/button/expiry levels, sees commands
//   slave  : controller side, samples levels, drives commands and status
interface stopwatch_timer_ctrl_if;
  logic mode_req;
  logic btn_start_stop;
  logic btn_reset;
  logic btn_min;
  logic btn_sec;
  logic timer_done;
  logic mode_sw;
  logic start;
  logic stop;
  logic reset;
  logic inc_min;
  logic inc_sec;
  logic running;
  logic alarm;

  modport master (
    output mode_req, btn_start_stop, btn_reset, btn_min, btn_sec, timer_done,
    input  mode_sw, start, stop, reset, inc_min, inc_sec, running, alarm
  );

  modport slave (
    input  mode_req, btn_start_stop, btn_reset, btn_min, btn_sec, timer_done,
    output mode_sw, start, stop, reset, inc_min, inc_sec, running, alarm
  );
endinterface

// File: rtl/stopwatch_timer_ctrl_rise_detect.sv
// 1-bit rising-edge detector: registers the previous level and flags a
// cycle where the input is 1 after being 0.
//   clk, rst_n : clock, synchronous active-low reset (history cleared to 0)
//   d          : level input
//   rise       : high while d=1 and the previous sample was 0
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) d_p1 <= 1'b0;
    else        d_p1 <= d;
  end

  assign rise = d & ~d_p1;
endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// Front-panel sequencer: turns debounced button levels and the mode switch
// into one-cycle start/stop/reset/inc_min/inc_sec pulses, registers the
// mode select, tracks run state and latches timer expiry into a timed alarm.
// Optional macro AUTO_REPEAT_EN: auto-repeat of held min/sec buttons.
//   clk, rst_n : clock, synchronous active-low reset
//   tick_1khz  : one-cycle 1 kHz enable for alarm timeout / repeat timing
//   ctrl       : panel interface (slave modport)
module stopwatch_timer_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int ALARM_MS        = 5000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_1khz,
  stopwatch_timer_ctrl_if.slave  ctrl
);
  localparam int AW = cnt_width(ALARM_MS);

  if (ALARM_MS < 1 || REPEAT_RATE_MS < 1 || REPEAT_DELAY_MS < REPEAT_RATE_MS) begin : g_bad_cfg
    $fatal(1, "stopwatch_timer_ctrl: invalid ALARM/REPEAT parameters");
  end

  logic ss_rise, rs_rise, min_rise, sec_rise, done_rise;
  logic rpt_min, rpt_sec;

  rise_detect u_rd_ss   (.clk(clk), .rst_n(rst_n), .d(ctrl.btn_start_stop), .rise(ss_rise));
  rise_detect u_rd_rs   (.clk(clk), .rst_n(rst_n), .d(ctrl.btn_reset),      .rise(rs_rise));
  rise_detect u_rd_min  (.clk(clk), .rst_n(rst_n), .d(ctrl.btn_min),        .rise(min_rise));
  rise_detect u_rd_sec  (.clk(clk), .rst_n(rst_n), .d(ctrl.btn_sec),        .rise(sec_rise));
  rise_detect u_rd_done (.clk(clk), .rst_n(rst_n), .d(ctrl.timer_done),     .rise(done_rise));

  ctrl_state_t   state_p0, state_p1;
  logic          mode_p0, mode_p1;
  cmd_t          cmd_p0, cmd_p1;
  logic [AW-1:0] alarm_cnt_p0, alarm_cnt_p1;
  logic          inc_min_evt, inc_sec_evt;

  assign inc_min_evt = min_rise | rpt_min;
  assign inc_sec_evt = sec_rise | rpt_sec;

  // Stage p0: next state / command decode. The if/else chains encode the
  // priority reset > start_stop > mode change > inc.
  always_comb begin
    state_p0     = state_p1;
    mode_p0      = mode_p1;
    cmd_p0       = '0;
    alarm_cnt_p0 = alarm_cnt_p1;
    unique case (state_p1)
      IDLE: begin
        if (rs_rise) begin
          cmd_p0.reset = 1'b1;
        end else if (ss_rise) begin
          cmd_p0.start = 1'b1;
          state_p0     = RUNNING;
        end else if (ctrl.mode_req != mode_p1) begin
          mode_p0      = ctrl.mode_req;
          cmd_p0.reset = 1'b1;
        end else if (mode_p1 == MODE_TIMER) begin
          cmd_p0.inc_min = inc_min_evt;
          cmd_p0.inc_sec = inc_sec_evt;
        end
      end
      RUNNING: begin
        if (rs_rise) begin
          cmd_p0.stop  = 1'b1;
          cmd_p0.reset = 1'b1;
          state_p0     = IDLE;
        end else if (ss_rise) begin
          cmd_p0.stop = 1'b1;
          state_p0    = PAUSED;
        end else if (done_rise && mode_p1 == MODE_TIMER) begin
          cmd_p0.stop  = 1'b1;
          state_p0     = ALARM;
          alarm_cnt_p0 = AW'(ALARM_MS);
        end
      end
      PAUSED: begin
        if (rs_rise) begin
          cmd_p0.reset = 1'b1;
          state_p0     = IDLE;
        end else if (ss_rise) begin
          cmd_p0.start = 1'b1;
          state_p0     = RUNNING;
        end else if (ctrl.mode_req != mode_p1) begin
          mode_p0      = ctrl.mode_req;
          cmd_p0.reset = 1'b1;
          state_p0     = IDLE;
        end else if (mode_p1 == MODE_TIMER) begin
          cmd_p0.inc_min = inc_min_evt;
          cmd_p0.inc_sec = inc_sec_evt;
        end
      end
      ALARM: begin
        // Any press only acknowledges the alarm.
        if (rs_rise || ss_rise || min_rise || sec_rise) begin
          cmd_p0.reset = 1'b1;
          state_p0     = IDLE;
        end else if (tick_1khz) begin
          if (alarm_cnt_p1 <= AW'(1)) begin
            cmd_p0.reset = 1'b1;
            state_p0     = IDLE;
            alarm_cnt_p0 = '0;
          end else begin
            alarm_cnt_p0 = alarm_cnt_p1 - 1'b1;
          end
        end
      end
      default: state_p0 = IDLE;
    endcase
  end

  // Stage p1: registered state, mode select and command pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1     <= IDLE;
      mode_p1      <= ctrl.mode_req;
      cmd_p1       <= '0;
      alarm_cnt_p1 <= '0;
    end else begin
      state_p1     <= state_p0;
      mode_p1      <= mode_p0;
      cmd_p1       <= cmd_p0;
      alarm_cnt_p1 <= alarm_cnt_p0;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_DELAY_MS);
  localparam logic [RW-1:0] HOLD_FIRE   = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] HOLD_RELOAD = RW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);

  logic          rpt_elig;
  logic [RW-1:0] hold_min_p1, hold_sec_p1;

  // Counters count ticks since the press edge; on reaching the delay they
  // fire and rewind by one repeat period.
  assign rpt_elig = (state_p1 == IDLE || state_p1 == PAUSED) && (mode_p1 == MODE_TIMER);
  assign rpt_min  = rpt_elig && ctrl.btn_min && !min_rise && tick_1khz && (hold_min_p1 == HOLD_FIRE);
  assign rpt_sec  = rpt_elig && ctrl.btn_sec && !sec_rise && tick_1khz && (hold_sec_p1 == HOLD_FIRE);

  always_ff @(posedge clk) begin
    if (!rst_n || !rpt_elig || !ctrl.btn_min || min_rise || state_p0 != state_p1)
      hold_min_p1 <= '0;
    else if (tick_1khz)
      hold_min_p1 <= (hold_min_p1 == HOLD_FIRE) ? HOLD_RELOAD : hold_min_p1 + 1'b1;

    if (!rst_n || !rpt_elig || !ctrl.btn_sec || sec_rise || state_p0 != state_p1)
      hold_sec_p1 <= '0;
    else if (tick_1khz)
      hold_sec_p1 <= (hold_sec_p1 == HOLD_FIRE) ? HOLD_RELOAD : hold_sec_p1 + 1'b1;
  end
`else
  assign rpt_min = 1'b0;
  assign rpt_sec = 1'b0;
`endif

  assign ctrl.mode_sw = mode_p1;
  assign ctrl.start   = cmd_p1.start;
  assign ctrl.stop    = cmd_p1.stop;
  assign ctrl.reset   = cmd_p1.reset;
  assign ctrl.inc_min = cmd_p1.inc_min;
  assign ctrl.inc_sec = cmd_p1.inc_sec;
  assign ctrl.running = (state_p1 == RUNNING);
  assign ctrl.alarm   = (state_p1 == ALARM);
endmodule

// File: doc/stopwatch_timer_ctrl.md
Name: stopwatch_timer_ctrl

Overview:
Front-panel control sequencer for the stopwatch/timer datapath wrapper. It converts debounced button levels and the mode switch into single-cycle start/stop/reset/inc_min/inc_sec command pulses and a registered mode select. It tracks run state and locks the mode while counting. It latches timer expiry into an alarm state with timeout. It sits between the debouncers and the stopwatch/timer wrapper in the lab top level.

Parameters:
ALARM_MS, 5000, alarm-state duration in tick_1khz periods before auto-clear (must be >= 1)
REPEAT_DELAY_MS, 500, hold time before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_RATE_MS, 100, auto-repeat period (AUTO_REPEAT_EN only)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
tick_1khz  input  1  one-clk-wide enable pulse at 1 kHz, synchronous to clk
mode_req  input  1  raw mode switch level: 1 = stopwatch, 0 = timer
btn_start_stop  input  1  debounced level, toggles run/pause
btn_reset  input  1  debounced level, clear
btn_min  input  1  debounced level, increment minutes (timer mode only)
btn_sec  input  1  debounced level, increment seconds (timer mode only)
timer_done  input  1  blink/expiry level from the wrapper
mode_sw  output  1  registered mode select to the wrapper
start, stop, reset, inc_min, inc_sec  output  1 each  one-clk command pulses
running  output  1  high in RUNNING
alarm  output  1  high in ALARM

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; mode_sw=mode_req sampled that cycle; all pulses 0; running=0; alarm=0; edge-history regs=0; counters=0. Reset mid-operation aborts any state. No command pulse is issued on reset.
- Edge detect: a button is "pressed" at cycle N if it is sampled 1 at N and 0 at N-1. The resulting pulse is registered and high during cycle N+1 only. Fixed latency is 1 clk.
- Priority within a cycle: reset > start_stop > mode change > inc. The lower-priority events in the same cycle are discarded. btn_min and btn_sec pressed together both pulse in the same cycle.
- States are IDLE, RUNNING, PAUSED and ALARM.
- IDLE:
  - start_stop press -> start pulse, go to RUNNING.
  - reset press -> reset pulse, stay in IDLE.
  - inc press while mode_sw=0 -> inc pulse. Ignored when mode_sw=1.
  - mode_req != mode_sw -> mode_sw updates and a reset pulse is issued in the same cycle.
- RUNNING:
  - start_stop press -> stop pulse, go to PAUSED.
  - reset press -> stop and reset pulses together, go to IDLE.
  - timer_done rising edge while mode_sw=0 -> stop pulse, go to ALARM, load alarm counter.
  - mode_req changes are ignored; mode_sw holds. If mode_req still differs on leaving RUNNING, the change is applied in the first non-RUNNING cycle.
  - inc presses are ignored.
- PAUSED:
  - start_stop press -> start pulse, go to RUNNING.
  - reset press -> reset pulse, go to IDLE.
  - inc press in timer mode -> inc pulse.
  - mode change -> mode_sw update plus reset pulse, go to IDLE.
- ALARM:
  - alarm=1. The counter decrements on each tick_1khz.
  - At 0, or on any button press, issue a reset pulse and go to IDLE.
  - A button press in ALARM performs no other action.
- timer_done is edge-detected. Holding it high does not retrigger.
- running is combinational from the state register (state==RUNNING).

Optional Feature:
AUTO_REPEAT_EN
- Defined: when btn_min/btn_sec is held in timer mode in IDLE or PAUSED, the first pulse fires on the press edge. After REPEAT_DELAY_MS ticks of continuous hold, a further pulse fires every REPEAT_RATE_MS ticks. Release or a state change clears the hold counter. Each button has its own counter.
- Undefined: exactly one pulse per press and no hold counters. REPEAT_* parameters are unused.

Decomposition:
- Package stopwatch_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, RUNNING, PAUSED, ALARM}
  - localparam MODE_STOPWATCH=1'b1 and MODE_TIMER=1'b0
  - a function clog2-based width helper for the ms counters
- One sub-module, rise_detect: a 1-bit registered rising-edge detector with synchronous active-low reset, instantiated per button and for timer_done.

Test Plan:
- Reset with mode_req=0, then press start_stop -> start high exactly 1 clk, one cycle after the press; running=1. Press again -> stop pulse; running=0 (PAUSED).
- In RUNNING, toggle mode_req -> mode_sw unchanged. Pause -> next cycle mode_sw=1, reset pulse, state IDLE.
- Timer mode IDLE, press btn_min and btn_sec in the same cycle -> inc_min and inc_sec both 1 for 1 clk. Switch to stopwatch mode and repeat -> no pulses.
- RUNNING in timer mode, raise timer_done -> stop pulse, alarm=1. With no buttons, after 5000 ticks -> reset pulse, alarm=0, IDLE.
- Press btn_reset and btn_start_stop in the same cycle while RUNNING -> stop and reset pulses, no start; state IDLE.
- With AUTO_REPEAT_EN, hold btn_sec for 800 ticks -> pulses at press, at 500, 600 and 700 ticks (4 total). Without the macro -> 1 pulse.
